// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipeline_ctrl_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned TMO_W  = 8;

  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } ctrl_state_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/pipeline_ctrl_fwd_unit.sv
// E-stage operand forwarding select for one source register; M beats W.
module pipeline_ctrl_fwd_unit
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] m_rd,
  input  logic       m_reg_write,
  input  logic [4:0] w_rd,
  input  logic       w_reg_write,
  output logic [1:0] fwd_c
);

  always_comb begin
    fwd_c = FWD_REG;
    if (m_reg_write && (m_rd != '0) && (m_rd == rs)) begin
      fwd_c = FWD_M;
    end else if (w_reg_write && (w_rd != '0) && (w_rd == rs)) begin
      fwd_c = FWD_W;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller: load-use stalls, branch flushes, data-memory waits
// with timeout, debug halt, operand forwarding and a stall-cycle counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           D_rs1,
  input  logic [4:0]           D_rs2,
  input  logic [4:0]           E_rs1,
  input  logic [4:0]           E_rs2,
  input  logic [4:0]           E_rd,
  input  logic                 E_RegWrite,
  input  logic [1:0]           E_result_src,
  input  logic                 E_pc_src,
  input  logic [4:0]           M_rd,
  input  logic                 M_RegWrite,
  input  logic                 M_mem_access,
  input  logic [4:0]           W_rd,
  input  logic                 W_RegWrite,
  input  logic                 dmem_ready,
  input  logic                 halt_req,
  output logic                 F_en,
  output logic                 F_D_en,
  output logic                 D_E_en,
  output logic                 E_M_en,
  output logic                 M_W_en,
  output logic                 F_D_flush,
  output logic                 D_E_flush,
  output logic [1:0]           E_fwd_a,
  output logic [1:0]           E_fwd_b,
  output logic                 dmem_req,
  output logic                 mem_fault,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] stall_cycles
);

  ctrl_state_t          state_q, state_d;
  logic [TMO_W-1:0]     cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;

  logic load_use_c;
  logic timeout_c;
  logic freeze_c;
  logic branch_c;
  logic lu_stall_c;
  logic fault_c;

  assign load_use_c = (E_result_src == RESULT_SRC_MEM) && E_RegWrite && (E_rd != '0) &&
                      ((E_rd == D_rs1) || (E_rd == D_rs2));
  assign timeout_c  = (cnt_q == TMO_W'(MEM_TIMEOUT - 1));

  // Next state, counters and pipeline control
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    freeze_c   = 1'b0;
    branch_c   = 1'b0;
    lu_stall_c = 1'b0;
    fault_c    = 1'b0;
    dmem_req   = 1'b0;
    halted     = 1'b0;

    unique case (state_q)
      RUN: begin
        dmem_req = M_mem_access;
        if (M_mem_access && !dmem_ready) begin
          freeze_c = 1'b1;
          cnt_d    = '0;
          state_d  = MEM_WAIT;
        end else if (E_pc_src) begin
          branch_c = 1'b1;
        end else if (load_use_c) begin
          lu_stall_c = 1'b1;
        end else if (halt_req && !M_mem_access) begin
          freeze_c = 1'b1;
          state_d  = HALTED;
        end
      end
      MEM_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ready || timeout_c) begin
          // Release: frozen branch/load-use hazards take effect now; halt is ignored
          fault_c    = !dmem_ready;
          cnt_d      = '0;
          state_d    = RUN;
          branch_c   = E_pc_src;
          lu_stall_c = !E_pc_src && load_use_c;
        end else begin
          freeze_c = 1'b1;
          cnt_d    = cnt_q + TMO_W'(1);
        end
      end
      HALTED: begin
        freeze_c = 1'b1;
        halted   = 1'b1;
        if (!halt_req) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    F_en      = !(freeze_c || lu_stall_c);
    F_D_en    = !(freeze_c || lu_stall_c);
    D_E_en    = !freeze_c;
    E_M_en    = !freeze_c;
    M_W_en    = !freeze_c;
    F_D_flush = branch_c;
    D_E_flush = branch_c || lu_stall_c;
    mem_fault = fault_c && rst;

    stall_cycles_d = stall_cycles_q;
    if (!F_en && (stall_cycles_q != {CNT_WIDTH{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

  pipeline_ctrl_fwd_unit u_fwd_a (
    .rs          (E_rs1),
    .m_rd        (M_rd),
    .m_reg_write (M_RegWrite),
    .w_rd        (W_rd),
    .w_reg_write (W_RegWrite),
    .fwd_c       (E_fwd_a)
  );

  pipeline_ctrl_fwd_unit u_fwd_b (
    .rs          (E_rs2),
    .m_rd        (M_rd),
    .m_reg_write (M_RegWrite),
    .w_rd        (W_rd),
    .w_reg_write (W_RegWrite),
    .fwd_c       (E_fwd_b)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (short timeout, narrow counter).
module tb_pipeline_ctrl;

  localparam int unsigned CW = 4;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    D_rs1, D_rs2, E_rs1, E_rs2, E_rd, M_rd, W_rd;
  logic          E_RegWrite, E_pc_src, M_RegWrite, M_mem_access, W_RegWrite;
  logic [1:0]    E_result_src;
  logic          dmem_ready, halt_req;
  logic          F_en, F_D_en, D_E_en, E_M_en, M_W_en, F_D_flush, D_E_flush;
  logic [1:0]    E_fwd_a, E_fwd_b;
  logic          dmem_req, mem_fault, halted;
  logic [CW-1:0] stall_cycles;
  logic [4:0]    en;
  logic [1:0]    fl;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign en = {F_en, F_D_en, D_E_en, E_M_en, M_W_en};
  assign fl = {F_D_flush, D_E_flush};

  pipeline_ctrl #(.MEM_TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .D_rs1(D_rs1), .D_rs2(D_rs2), .E_rs1(E_rs1), .E_rs2(E_rs2), .E_rd(E_rd),
    .E_RegWrite(E_RegWrite), .E_result_src(E_result_src), .E_pc_src(E_pc_src),
    .M_rd(M_rd), .M_RegWrite(M_RegWrite), .M_mem_access(M_mem_access),
    .W_rd(W_rd), .W_RegWrite(W_RegWrite), .dmem_ready(dmem_ready), .halt_req(halt_req),
    .F_en(F_en), .F_D_en(F_D_en), .D_E_en(D_E_en), .E_M_en(E_M_en), .M_W_en(M_W_en),
    .F_D_flush(F_D_flush), .D_E_flush(D_E_flush), .E_fwd_a(E_fwd_a), .E_fwd_b(E_fwd_b),
    .dmem_req(dmem_req), .mem_fault(mem_fault), .halted(halted), .stall_cycles(stall_cycles)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    D_rs1 = '0; D_rs2 = '0; E_rs1 = '0; E_rs2 = '0; E_rd = '0; M_rd = '0; W_rd = '0;
    E_RegWrite = 1'b0; E_pc_src = 1'b0; M_RegWrite = 1'b0; M_mem_access = 1'b0;
    W_RegWrite = 1'b0; E_result_src = 2'b00; dmem_ready = 1'b0; halt_req = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    tick();
    tick();
    check("rst_en", 32'(en), 32'h1f);
    check("rst_fl", 32'(fl), 32'h0);
    check("rst_fwd", 32'({E_fwd_a, E_fwd_b}), 32'h0);
    check("rst_req", 32'(dmem_req), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_fault", 32'(mem_fault), 32'h0);
    check("rst_stall", 32'(stall_cycles), 32'h0);
    rst = 1'b1;

    // Load-use on x5, then forwarding from W and M priority
    E_result_src = 2'b01; E_RegWrite = 1'b1; E_rd = 5'd5; D_rs1 = 5'd5;
    #1;
    check("lu_en", 32'(en), 32'h07);
    check("lu_fl", 32'(fl), 32'h1);
    tick();
    idle();
    E_rs1 = 5'd5; E_rs2 = 5'd5; E_rd = 5'd6; W_rd = 5'd5; W_RegWrite = 1'b1;
    #1;
    check("lu_next_en", 32'(en), 32'h1f);
    check("lu_next_fl", 32'(fl), 32'h0);
    check("fwd_a_w", 32'(E_fwd_a), 32'h1);
    check("lu_stall_cnt", 32'(stall_cycles), 32'h1);
    E_rs2 = 5'd7; M_rd = 5'd5; M_RegWrite = 1'b1;
    #1;
    check("fwd_a_m_prio", 32'(E_fwd_a), 32'h2);
    check("fwd_b_none", 32'(E_fwd_b), 32'h0);
    M_rd = 5'd7;
    #1;
    check("fwd_b_m", 32'(E_fwd_b), 32'h2);
    check("fwd_a_w2", 32'(E_fwd_a), 32'h1);

    // x0 destination: no stall, no forwarding
    idle();
    E_result_src = 2'b01; E_RegWrite = 1'b1; E_rd = 5'd0; D_rs1 = 5'd0;
    M_rd = 5'd0; M_RegWrite = 1'b1; W_rd = 5'd0; W_RegWrite = 1'b1;
    #1;
    check("x0_en", 32'(en), 32'h1f);
    check("x0_fwd", 32'({E_fwd_a, E_fwd_b}), 32'h0);

    // Branch beats load-use
    idle();
    E_result_src = 2'b01; E_RegWrite = 1'b1; E_rd = 5'd3; D_rs2 = 5'd3; E_pc_src = 1'b1;
    #1;
    check("br_prio_en", 32'(en), 32'h1f);
    check("br_prio_fl", 32'(fl), 32'h3);
    tick();

    // Memory wait: 3 stalled cycles then ready
    idle();
    M_mem_access = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mw_en", 32'(en), 32'h0);
      check("mw_req", 32'(dmem_req), 32'h1);
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    check("mw_rel_en", 32'(en), 32'h1f);
    check("mw_rel_req", 32'(dmem_req), 32'h1);
    check("mw_rel_fault", 32'(mem_fault), 32'h0);
    tick();
    check("mw_stall_cnt", 32'(stall_cycles), 32'h4);
    // Zero wait states in RUN
    #1;
    check("zw_en", 32'(en), 32'h1f);
    check("zw_req", 32'(dmem_req), 32'h1);
    tick();
    idle();
    #1;
    check("idle_req", 32'(dmem_req), 32'h0);

    // Branch held during memory wait flushes only on release
    M_mem_access = 1'b1; E_pc_src = 1'b1;
    #1;
    check("wbr_run_fl", 32'(fl), 32'h0);
    check("wbr_run_en", 32'(en), 32'h0);
    tick();
    #1;
    check("wbr_wait_fl", 32'(fl), 32'h0);
    tick();
    dmem_ready = 1'b1;
    #1;
    check("wbr_rel_fl", 32'(fl), 32'h3);
    check("wbr_rel_en", 32'(en), 32'h1f);
    tick();
    check("wbr_stall_cnt", 32'(stall_cycles), 32'h6);

    // Timeout: fault in the 4th MEM_WAIT cycle
    idle();
    M_mem_access = 1'b1;
    #1;
    check("to_run_fault", 32'(mem_fault), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("to_fault", 32'(mem_fault), 32'((i == 3) ? 1 : 0));
      check("to_en", 32'(en), (i == 3) ? 32'h1f : 32'h0);
    end
    tick();
    M_mem_access = 1'b0;
    #1;
    check("to_back_en", 32'(en), 32'h1f);
    check("to_back_fault", 32'(mem_fault), 32'h0);
    check("to_stall_cnt", 32'(stall_cycles), 32'ha);

    // Ready coincides with timeout: no fault
    M_mem_access = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    dmem_ready = 1'b1;
    #1;
    check("to_ready_fault", 32'(mem_fault), 32'h0);
    check("to_ready_en", 32'(en), 32'h1f);
    tick();
    check("to_ready_cnt", 32'(stall_cycles), 32'he);

    // Halt, saturation, resume
    idle();
    halt_req = 1'b1;
    #1;
    check("h_run_en", 32'(en), 32'h0);
    check("h_run_halted", 32'(halted), 32'h0);
    tick();
    check("h_halted", 32'(halted), 32'h1);
    check("h_en", 32'(en), 32'h0);
    check("h_req", 32'(dmem_req), 32'h0);
    tick();
    check("h_sat", 32'(stall_cycles), 32'hf);
    halt_req = 1'b0;
    #1;
    check("h_drop_en", 32'(en), 32'h0);
    tick();
    check("h_resume_en", 32'(en), 32'h1f);
    check("h_resume_halted", 32'(halted), 32'h0);
    check("h_sat_hold", 32'(stall_cycles), 32'hf);

    // Reset while halted
    halt_req = 1'b1;
    tick();
    check("h2_halted", 32'(halted), 32'h1);
    halt_req = 1'b0;
    rst = 1'b0;
    tick();
    check("rh_halted", 32'(halted), 32'h0);
    check("rh_stall", 32'(stall_cycles), 32'h0);
    check("rh_en", 32'(en), 32'h1f);
    rst = 1'b1;

    // Reset at the timeout cycle drops the fault
    M_mem_access = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b0;
    #1;
    check("rw_fault_drop", 32'(mem_fault), 32'h0);
    tick();
    M_mem_access = 1'b0;
    #1;
    check("rw_en", 32'(en), 32'h1f);
    check("rw_stall", 32'(stall_cycles), 32'h0);
    rst = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
